keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001: Parameter SCAN_DIV, default 960000; clk cycles each column is driven before its rows are sampled; legal range 4..2^20.
REQ-002: clk  input  1  system clock; one clock domain, all state updates on rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: rows  input  4  keypad row pins, active-low (external pull-ups), asynchronous to clk.
REQ-005: cols  output  4  keypad column drives, active-low one-hot, registered.
REQ-006: key_code  output  4  hex value of the detected key, registered.
REQ-007: key_pressed  output  1  high while one key is detected and held; feeds the downstream debouncer.

Function
REQ-008: rows SHALL pass through a 2-flop synchronizer (rows_sync); rows_sync lags rows by 2 cycles.
REQ-009: A 20-bit counter SHALL count 0..SCAN_DIV-1 and wrap to 0; it runs in every state.
REQ-010: FSM states SCAN and HOLD.
REQ-011: SCAN: on counter==SCAN_DIV-1, if exactly one rows_sync bit is 0 -> next state HOLD, key_pressed<=1, key_code<=map(row,active col), cols unchanged.
REQ-012: SCAN: on counter==SCAN_DIV-1 with zero or 2+ rows_sync bits low -> stay SCAN, cols rotate 1110->1101->1011->0111->1110.
REQ-013: SCAN: on any other cycle, all outputs hold.
REQ-014: HOLD: cols frozen; on counter==SCAN_DIV-1, if rows_sync==4'b1111 -> next state SCAN, key_pressed<=0, cols advance one step; otherwise stay HOLD.
REQ-015: HOLD: a different or additional row going low does not change key_code; only full release exits HOLD.
REQ-016: key_code SHALL retain its last value after release until the next detection.
REQ-017: Key map (row r, col c): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D.
REQ-018: Detection latency: key_pressed rises on the cycle after the sampling cycle (counter==SCAN_DIV-1) of the active column; rows must be low >=3 cycles before that edge to be seen.
REQ-019: Row activity shorter than the synchronizer delay, or not present at the sampling cycle, SHALL be ignored.
REQ-020: key_pressed and key_code SHALL change only together on entry to HOLD; key_pressed alone on exit.

Reset
REQ-021: While reset is high: state=SCAN, counter=0, cols=4'b1110, key_code=4'h0, key_pressed=0, synchronizer flops=4'b1111, all applied immediately without a clock edge.
REQ-022: Reset asserted mid-HOLD SHALL drop key_pressed asynchronously; scanning restarts at column 0 on the first edge after release.

Structure
REQ-023: Package keypad_pkg SHALL hold the state enum type, the 4x4 key-map constant table and the column-rotation reset constant 4'b1110.
REQ-024: One sub-module, sync_2ff (4-bit, async-reset to all-ones), SHALL implement REQ-008; the rest stays flat in keypad_scanner.
REQ-025: SCAN_DIV overridden to 4 in all benches; the synthesised default is 960000 (~20 ms/column at 48 MHz).

Verification (SCAN_DIV=4)
REQ-026: Rotation idle: rows=4'b1111 after reset -> cols 1110,1101,1011,0111,1110, each held exactly 4 cycles; key_pressed stays 0.
REQ-027: Press '5': model pulls row1 low whenever cols[1]==0 -> key_pressed=1, key_code=4'h5, cols frozen at 4'b1101 while held.
REQ-028: Release '5' -> key_pressed=0 within 4+2 cycles, cols next 4'b1011, key_code remains 4'h5.
REQ-029: Press row0 and row2 together on col3 -> no detection, key_pressed=0, rotation continues uninterrupted.
REQ-030: Hold 'D' (row3,col3), assert reset for 1 cycle -> key_pressed=0, key_code=4'h0, cols=4'b1110 during reset; with key still held, re-detect gives key_code=4'hD once col3 is reached.
REQ-031: 1-cycle low glitch on row2 during col0 not spanning its sampling cycle -> no detection.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key map and decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [0:0] {
        ST_SCAN = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Indexed by {row, col}; entry 0 (rightmost) is row0/col0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic single_low(input logic [3:0] v);
        logic hit;
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones (idle rows).
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b1}};
            sync_r <= {WIDTH{1'b1}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive and latches
// the first single-row hit, holding it until every row is released.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_pressed
);

    localparam logic [19:0] LAST_CNT = 20'(SCAN_DIV - 1);

    logic [3:0]  rows_sync;
    logic [19:0] cnt_r;
    state_t      state_r;
    logic [3:0]  cols_r;
    logic [3:0]  key_code_r;
    logic        key_pressed_r;

    logic        last_s;
    logic        one_low_s;
    logic [3:0]  cols_next_s;
    logic [1:0]  row_idx_s;
    logic [1:0]  col_idx_s;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_sync)
    );

    assign last_s      = (cnt_r == LAST_CNT);
    assign one_low_s   = single_low(rows_sync);
    assign row_idx_s   = low_index(rows_sync);
    assign col_idx_s   = low_index(cols_r);
    assign cols_next_s = {cols_r[2:0], cols_r[3]};

    // Free-running column period counter, independent of FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 20'd0;
        end else if (last_s) begin
            cnt_r <= 20'd0;
        end else begin
            cnt_r <= cnt_r + 20'd1;
        end
    end

    // Scan/hold FSM; all decisions are taken only on the sampling cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_SCAN;
            cols_r        <= COL_RESET;
            key_code_r    <= 4'h0;
            key_pressed_r <= 1'b0;
        end else begin
            case (state_r)
                ST_SCAN: begin
                    if (last_s) begin
                        if (one_low_s) begin
                            state_r       <= ST_HOLD;
                            key_pressed_r <= 1'b1;
                            key_code_r    <= KEY_MAP[{row_idx_s, col_idx_s}];
                        end else begin
                            cols_r <= cols_next_s;
                        end
                    end
                end
                ST_HOLD: begin
                    // Only a full release leaves HOLD; extra rows are ignored.
                    if (last_s && (rows_sync == 4'b1111)) begin
                        state_r       <= ST_SCAN;
                        key_pressed_r <= 1'b0;
                        cols_r        <= cols_next_s;
                    end
                end
                default: begin
                    state_r <= ST_SCAN;
                end
            endcase
        end
    end

    assign cols        = cols_r;
    assign key_code    = key_code_r;
    assign key_pressed = key_pressed_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with SCAN_DIV = 4.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_pressed;

    logic [15:0] keys;    // bit {row,col} set while that key is held
    logic        glitch;  // forces row2 low regardless of columns

    int checks;
    int errors;

    keypad_scanner #(.SCAN_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .rows        (rows),
        .cols        (cols),
        .key_code    (key_code),
        .key_pressed (key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a held key shorts its row to its column when driven low.
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
        if (glitch) rows[2] = 1'b0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] rot(input logic [3:0] start, input int steps);
        logic [3:0] v;
        v = start;
        for (int i = 0; i < steps; i++) v = {v[2:0], v[3]};
        return v;
    endfunction

    // Waits up to max_cycles negedges for key_pressed to reach level.
    task automatic wait_kp(input logic level, input int max_cycles, input string tag, output int used);
        used = 0;
        while (key_pressed !== level && used < max_cycles) begin
            @(negedge clk);
            used++;
        end
        check_eq(tag, {31'd0, key_pressed}, {31'd0, level});
    endtask

    int n;

    initial begin
        checks = 0;
        errors = 0;
        keys   = 16'h0000;
        glitch = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_cols", {28'd0, cols}, 32'h0000000E);
        check_eq("rst_code", {28'd0, key_code}, 32'h0);
        check_eq("rst_kp", {31'd0, key_pressed}, 32'h0);
        reset = 1'b0;

        // Idle rotation: first column includes the reset period.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check_eq("idle_cols", {28'd0, cols}, {28'd0, rot(4'b1110, k / 4)});
            check_eq("idle_kp", {31'd0, key_pressed}, 32'h0);
        end

        // Press '5' (row1, col1).
        keys[1*4+1] = 1'b1;
        wait_kp(1'b1, 40, "press5_kp", n);
        check_eq("press5_code", {28'd0, key_code}, 32'h5);
        check_eq("press5_cols", {28'd0, cols}, 32'hD);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_eq("hold5_cols", {28'd0, cols}, 32'hD);
            check_eq("hold5_kp", {31'd0, key_pressed}, 32'h1);
        end

        // Release '5'.
        keys = 16'h0000;
        wait_kp(1'b0, 6, "rel5_kp", n);
        check_eq("rel5_cols", {28'd0, cols}, 32'hB);
        check_eq("rel5_code", {28'd0, key_code}, 32'h5);

        // Rows 0 and 2 together on col3: ignored, rotation continues (phase: cnt=0).
        keys[0*4+3] = 1'b1;
        keys[2*4+3] = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            check_eq("dbl_cols", {28'd0, cols}, {28'd0, rot(4'b1011, j / 4)});
            check_eq("dbl_kp", {31'd0, key_pressed}, 32'h0);
        end
        keys = 16'h0000;

        // Hold 'D' (row3, col3), then pulse reset mid-hold.
        keys[3*4+3] = 1'b1;
        wait_kp(1'b1, 24, "pressD_kp", n);
        check_eq("pressD_code", {28'd0, key_code}, 32'hD);
        reset = 1'b1;
        #1;
        check_eq("arst_kp", {31'd0, key_pressed}, 32'h0);
        check_eq("arst_code", {28'd0, key_code}, 32'h0);
        check_eq("arst_cols", {28'd0, cols}, 32'hE);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_kp", {31'd0, key_pressed}, 32'h0);
        check_eq("post_rst_cols", {28'd0, cols}, 32'hE);
        wait_kp(1'b1, 24, "redetD_kp", n);
        check_eq("redetD_code", {28'd0, key_code}, 32'hD);
        check_eq("redetD_cols", {28'd0, cols}, 32'h7);

        // Release 'D'; the fall lands on the negedge after a sampling edge (cnt=0, col0).
        keys = 16'h0000;
        wait_kp(1'b0, 6, "relD_kp", n);
        check_eq("relD_cols", {28'd0, cols}, 32'hE);

        // One-cycle row2 glitch during col0 that clears before the sampling edge.
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        for (int j = 2; j <= 16; j++) begin
            @(negedge clk);
            check_eq("glitch_kp", {31'd0, key_pressed}, 32'h0);
            check_eq("glitch_cols", {28'd0, cols}, {28'd0, rot(4'b1110, j / 4)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
